udp_tx_arbiter: RTL and testbench
=================================

Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit port of the UDP/IP stack (header channel plus 8-bit AXI-Stream payload) between N independent requesters.
- Arbitration is round-robin and frame-atomic. Once a requester is granted, its header and its whole payload up to and including tlast pass through before any other requester is considered.
- Sits between application-level UDP sources and the UDP transmit input of the stack.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- REQ_IDX_WIDTH, $clog2(N_REQ), width of the grant index.
- DEFAULT_TTL, 64, value driven on m_udp_ip_ttl.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- s_hdr_valid  input  N_REQ  per-requester header valid.
- s_hdr_ready  output  N_REQ  per-requester header ready.
- s_dest_ip  input  N_REQ*32  per-requester destination IP.
- s_source_port  input  N_REQ*16  per-requester UDP source port.
- s_dest_port  input  N_REQ*16  per-requester UDP destination port.
- s_length  input  N_REQ*16  per-requester UDP length.
- s_tdata  input  N_REQ*8  per-requester payload data.
- s_tvalid  input  N_REQ  per-requester payload valid.
- s_tready  output  N_REQ  per-requester payload ready.
- s_tlast  input  N_REQ  per-requester payload last.
- s_tuser  input  N_REQ  per-requester payload error flag.
- m_udp_hdr_valid  output  1  shared header valid.
- m_udp_hdr_ready  input  1  shared header ready.
- m_udp_ip_dest_ip  output  32  shared destination IP.
- m_udp_source_port  output  16  shared source port.
- m_udp_dest_port  output  16  shared destination port.
- m_udp_length  output  16  shared UDP length.
- m_udp_ip_ttl  output  8  constant DEFAULT_TTL.
- m_udp_ip_dscp  output  6  constant 0.
- m_udp_ip_ecn  output  2  constant 0.
- m_udp_checksum  output  16  constant 0 (checksum is generated in the stack).
- m_tdata  output  8  shared payload data.
- m_tvalid  output  1  shared payload valid.
- m_tready  input  1  shared payload ready.
- m_tlast  output  1  shared payload last.
- m_tuser  output  1  shared payload error flag.
- grant_valid  output  1  a requester currently owns the port.
- grant_idx  output  REQ_IDX_WIDTH  index of the owning requester.
- frame_count  output  32  number of frames completed (wraps).

Behaviour:
- Reset (async assert, sync deassert):
  - State is IDLE and the round-robin pointer is 0.
  - grant_valid=0, grant_idx=0, frame_count=0.
  - All s_hdr_ready=0, all s_tready=0, m_udp_hdr_valid=0, m_tvalid=0.
  - Reset mid-frame abandons the frame with no tlast emitted; a new grant is issued after reset.
- States: IDLE, HDR, PAYLOAD.
- IDLE:
  - If any s_hdr_valid is set, select the first set bit searching from the pointer upward, with wrap-around.
  - Register grant_idx, set grant_valid=1, go to HDR.
  - The grant appears in the cycle after s_hdr_valid is sampled.
  - No handshake occurs in IDLE.
- HDR:
  - m_udp_hdr_valid and the header fields are combinational from the granted requester.
  - s_hdr_ready[grant_idx]=m_udp_hdr_ready; all other ready bits are 0.
  - When valid and ready are both high, go to PAYLOAD.
- PAYLOAD:
  - m_tdata, m_tvalid, m_tlast and m_tuser come from the granted requester.
  - s_tready[grant_idx]=m_tready; all others are 0.
  - m_udp_hdr_valid=0.
  - When m_tvalid, m_tready and m_tlast are all high:
    - pointer=(grant_idx+1) mod N_REQ;
    - frame_count is incremented, wrapping 2^32-1 to 0;
    - grant_valid=0 and the block returns to IDLE.
- Minimum gap between frames is 1 IDLE cycle.
- A frame ending with tuser=1 is forwarded unchanged and still counts as a frame.
- Requester rules:
  - A non-granted requester holding s_hdr_valid sees no ready bits and must keep its header stable.
  - s_tvalid from a non-granted requester is ignored.
  - A requester dropping s_hdr_valid before the header handshake is a protocol violation. The arbiter keeps its grant regardless; no timeout.
- Zero-length payloads are not supported: every header must be followed by at least one beat carrying tlast.
- When grant_valid=0, the shared outputs carry data 0 and valid 0.

Test Plan:
- Single requester 1 sends an 8-byte frame with dest_port=0x1234 and sink always ready → grant_idx=1 one cycle after hdr_valid; m_udp_dest_port=0x1234; 8 beats with tlast on beat 8; frame_count=1.
- Requesters 0 and 2 both request with pointer=0 → 0 is served first, then 2. Requester 2's s_tready stays 0 until its own grant. Pointer ends at 3.
- All 4 requesters request continuously for 8 frames → grant order 0,1,2,3,0,1,2,3; frame_count=8; at least 1 IDLE cycle between frames.
- Sink toggles m_tready at random during requester 3's frame → byte sequence is intact, there is no interleaving from requester 0, which is holding valid, and tlast is seen exactly once.
- reset_n pulsed low mid-payload → all valids and readies are 0 within the same cycle, frame_count=0, and the next grant goes to the lowest pending index.
- frame_count preloaded via force to 0xFFFFFFFF, then one frame completes → frame_count=0.

Source files
------------

// File: rtl/udp_tx_arbiter.sv
// Round-robin, frame-atomic arbiter sharing one UDP transmit port (header
// channel plus 8-bit AXI-Stream payload) between N_REQ requesters.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// ST_IDLE  | no owner; search s_hdr_valid from rr_ptr upward and grant
// ST_HDR   | owner's header forwarded until the header handshake
// ST_PAYLOAD | owner's payload forwarded until the tlast handshake
module udp_tx_arbiter #(
    parameter int          N_REQ         = 4,
    parameter int          REQ_IDX_WIDTH = $clog2(N_REQ),
    parameter logic [7:0]  DEFAULT_TTL   = 8'd64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           s_hdr_valid,
    output logic [N_REQ-1:0]           s_hdr_ready,
    input  logic [N_REQ*32-1:0]        s_dest_ip,
    input  logic [N_REQ*16-1:0]        s_source_port,
    input  logic [N_REQ*16-1:0]        s_dest_port,
    input  logic [N_REQ*16-1:0]        s_length,
    input  logic [N_REQ*8-1:0]         s_tdata,
    input  logic [N_REQ-1:0]           s_tvalid,
    output logic [N_REQ-1:0]           s_tready,
    input  logic [N_REQ-1:0]           s_tlast,
    input  logic [N_REQ-1:0]           s_tuser,
    output logic                       m_udp_hdr_valid,
    input  logic                       m_udp_hdr_ready,
    output logic [31:0]                m_udp_ip_dest_ip,
    output logic [15:0]                m_udp_source_port,
    output logic [15:0]                m_udp_dest_port,
    output logic [15:0]                m_udp_length,
    output logic [7:0]                 m_udp_ip_ttl,
    output logic [5:0]                 m_udp_ip_dscp,
    output logic [1:0]                 m_udp_ip_ecn,
    output logic [15:0]                m_udp_checksum,
    output logic [7:0]                 m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic                       m_tuser,
    output logic                       grant_valid,
    output logic [REQ_IDX_WIDTH-1:0]   grant_idx,
    output logic [31:0]                frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [REQ_IDX_WIDTH-1:0] rr_ptr;
    logic [REQ_IDX_WIDTH-1:0] rr_ptr_nxt;
    logic [REQ_IDX_WIDTH-1:0] sel_idx;
    logic                     sel_found;
    logic                     hdr_done;
    logic                     frame_done;

    // The checksum is produced inside the stack; IP QoS fields are fixed.
    assign m_udp_ip_ttl   = DEFAULT_TTL;
    assign m_udp_ip_dscp  = 6'd0;
    assign m_udp_ip_ecn   = 2'd0;
    assign m_udp_checksum = 16'd0;

    // Round-robin search: walk offsets downward so the smallest offset from rr_ptr wins.
    always_comb begin
        sel_idx   = rr_ptr;
        sel_found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (s_hdr_valid[REQ_IDX_WIDTH'(j)]) begin
                sel_found = 1'b1;
                sel_idx   = REQ_IDX_WIDTH'(j);
            end
        end
    end

    assign hdr_done   = (state == ST_HDR) && s_hdr_valid[grant_idx] && m_udp_hdr_ready;
    assign frame_done = (state == ST_PAYLOAD) && s_tvalid[grant_idx] && m_tready
                        && s_tlast[grant_idx];
    assign rr_ptr_nxt = (grant_idx == REQ_IDX_WIDTH'(N_REQ - 1)) ? '0
                        : grant_idx + REQ_IDX_WIDTH'(1);

    // Next-state logic and the per-state routing of the shared port.
    always_comb begin
        state_nxt         = state;
        s_hdr_ready       = '0;
        s_tready          = '0;
        m_udp_hdr_valid   = 1'b0;
        m_udp_ip_dest_ip  = 32'd0;
        m_udp_source_port = 16'd0;
        m_udp_dest_port   = 16'd0;
        m_udp_length      = 16'd0;
        m_tdata           = 8'd0;
        m_tvalid          = 1'b0;
        m_tlast           = 1'b0;
        m_tuser           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_found) begin
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                m_udp_hdr_valid        = s_hdr_valid[grant_idx];
                m_udp_ip_dest_ip       = s_dest_ip[grant_idx*32 +: 32];
                m_udp_source_port      = s_source_port[grant_idx*16 +: 16];
                m_udp_dest_port        = s_dest_port[grant_idx*16 +: 16];
                m_udp_length           = s_length[grant_idx*16 +: 16];
                s_hdr_ready[grant_idx] = m_udp_hdr_ready;
                if (hdr_done) begin
                    state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                m_tdata             = s_tdata[grant_idx*8 +: 8];
                m_tvalid            = s_tvalid[grant_idx];
                m_tlast             = s_tlast[grant_idx];
                m_tuser             = s_tuser[grant_idx];
                s_tready[grant_idx] = m_tready;
                if (frame_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register, grant ownership, round-robin pointer and frame counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            frame_count <= 32'd0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && sel_found) begin
                grant_idx   <= sel_idx;
                grant_valid <= 1'b1;
            end
            if (frame_done) begin
                grant_valid <= 1'b0;
                rr_ptr      <= rr_ptr_nxt;
                frame_count <= frame_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: behavioural requesters and a payload
// monitor driven step by step from one initial block.
module tb_udp_tx_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      s_hdr_valid, s_hdr_ready;
    logic [N*32-1:0]   s_dest_ip;
    logic [N*16-1:0]   s_source_port, s_dest_port, s_length;
    logic [N*8-1:0]    s_tdata;
    logic [N-1:0]      s_tvalid, s_tready, s_tlast, s_tuser;
    logic              m_udp_hdr_valid, m_udp_hdr_ready;
    logic [31:0]       m_udp_ip_dest_ip;
    logic [15:0]       m_udp_source_port, m_udp_dest_port, m_udp_length;
    logic [7:0]        m_udp_ip_ttl;
    logic [5:0]        m_udp_ip_dscp;
    logic [1:0]        m_udp_ip_ecn;
    logic [15:0]       m_udp_checksum;
    logic [7:0]        m_tdata;
    logic              m_tvalid, m_tready, m_tlast, m_tuser;
    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [31:0]       frame_count;

    udp_tx_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
        .s_dest_ip(s_dest_ip), .s_source_port(s_source_port),
        .s_dest_port(s_dest_port), .s_length(s_length),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
        .m_udp_ip_dest_ip(m_udp_ip_dest_ip), .m_udp_source_port(m_udp_source_port),
        .m_udp_dest_port(m_udp_dest_port), .m_udp_length(m_udp_length),
        .m_udp_ip_ttl(m_udp_ip_ttl), .m_udp_ip_dscp(m_udp_ip_dscp),
        .m_udp_ip_ecn(m_udp_ip_ecn), .m_udp_checksum(m_udp_checksum),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .grant_valid(grant_valid), .grant_idx(grant_idx),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          pend[N], beat[N], len[N], mon_beat[N];
    logic [15:0] dport[N];
    bit          user_en[N];
    int          order_q[$];
    bit          leak;
    bit          rand_rdy;
    int          tot_beats;
    logic [31:0] fc_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int r, input int b);
        return 8'((r << 4) + b + 1);
    endfunction

    task automatic set_src(input int r);
        s_tdata[r*8 +: 8] = exp_byte(r, beat[r]);
        s_tlast[r]        = (beat[r] == len[r] - 1);
        s_tuser[r]        = (beat[r] == len[r] - 1) && user_en[r];
    endtask

    task automatic start_req(input int r, input int nfr, input int l,
                             input logic [15:0] dp, input bit ue);
        pend[r]    = nfr;
        len[r]     = l;
        dport[r]   = dp;
        user_en[r] = ue;
        beat[r]    = 0;
        s_dest_ip[r*32 +: 32]     = 32'h0A00_0000 + 32'(r);
        s_source_port[r*16 +: 16] = 16'h1000 + 16'(r);
        s_dest_port[r*16 +: 16]   = dp;
        s_length[r*16 +: 16]      = 16'(8 + l);
        s_tvalid[r]    = 1'b0;
        s_hdr_valid[r] = 1'b1;
        set_src(r);
    endtask

    task automatic clear_src();
        s_hdr_valid = '0; s_dest_ip = '0; s_source_port = '0; s_dest_port = '0;
        s_length = '0; s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
        for (int r = 0; r < N; r++) begin
            pend[r] = 0; beat[r] = 0; len[r] = 1; mon_beat[r] = 0;
            dport[r] = '0; user_en[r] = 1'b0;
        end
        order_q.delete();
        leak = 1'b0;
        tot_beats = 0;
    endtask

    // One clock: observe at the settled point, cross the edge, update requesters.
    task automatic cyc();
        bit       hh[N], dh[N];
        bit       fin;
        int       g;
        logic [3:0] gmask;
        gmask = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;
        if (((s_tready & ~gmask) != 0) || ((s_hdr_ready & ~gmask) != 0)) leak = 1'b1;
        if (!grant_valid && (m_tvalid || m_udp_hdr_valid || m_tdata != 8'd0)) leak = 1'b1;
        if (m_udp_hdr_valid && m_udp_hdr_ready) begin
            chk("hdr_dport", 32'(m_udp_dest_port), 32'(dport[grant_idx]));
            chk("hdr_dip", m_udp_ip_dest_ip, 32'h0A00_0000 + 32'(grant_idx));
        end
        fin = 1'b0;
        if (m_tvalid && m_tready) begin
            g = int'(grant_idx);
            tot_beats++;
            chk("beat_data", 32'(m_tdata), 32'(exp_byte(g, mon_beat[g])));
            chk("beat_last", 32'(m_tlast), 32'(mon_beat[g] == len[g] - 1));
            chk("beat_user", 32'(m_tuser), 32'((mon_beat[g] == len[g] - 1) && user_en[g]));
            if (m_tlast) begin
                mon_beat[g] = 0;
                order_q.push_back(g);
                fin = 1'b1;
            end else begin
                mon_beat[g]++;
            end
        end
        for (int r = 0; r < N; r++) begin
            hh[r] = s_hdr_valid[r] && s_hdr_ready[r];
            dh[r] = s_tvalid[r] && s_tready[r];
        end
        @(posedge clk);
        #1;
        if (fin) begin
            fc_exp = fc_exp + 32'd1;
            chk("idle_gap", 32'(grant_valid), 32'd0);
            chk("frame_count", frame_count, fc_exp);
        end
        for (int r = 0; r < N; r++) begin
            if (hh[r]) begin
                s_hdr_valid[r] = 1'b0;
                beat[r]        = 0;
                s_tvalid[r]    = 1'b1;
                set_src(r);
            end
            if (dh[r]) begin
                if (beat[r] == len[r] - 1) begin
                    s_tvalid[r] = 1'b0;
                    pend[r]--;
                    if (pend[r] > 0) s_hdr_valid[r] = 1'b1;
                end else begin
                    beat[r]++;
                    set_src(r);
                end
            end
        end
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
    endtask

    task automatic run(input int max_cyc);
        bit done;
        int n;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            cyc();
            n++;
            done = !grant_valid && (pend[0] == 0) && (pend[1] == 0)
                   && (pend[2] == 0) && (pend[3] == 0);
        end
        chk("run_done", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_src();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        fc_exp  = 32'd0;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        m_udp_hdr_ready = 1'b1;
        m_tready = 1'b1;
        rand_rdy = 1'b0;
        fc_exp = 32'd0;
        clear_src();
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_idx", 32'(grant_idx), 32'd0);
        chk("rst_frame_count", frame_count, 32'd0);
        chk("rst_hdr_ready", 32'(s_hdr_ready), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_m_valids", 32'({m_udp_hdr_valid, m_tvalid}), 32'd0);
        chk("ttl", 32'(m_udp_ip_ttl), 32'd64);
        chk("const_zero", 32'({m_udp_ip_dscp, m_udp_ip_ecn, m_udp_checksum}), 32'd0);
        reset_n = 1'b1;
        #1;

        // Requesters 0 and 2 with pointer 0: 0 first, then 2
        start_req(0, 1, 4, 16'h0100, 1'b0);
        start_req(2, 1, 4, 16'h0300, 1'b0);
        cyc();
        chk("a_grant_idx", 32'(grant_idx), 32'd0);
        chk("a_tready2_idle", 32'(s_tready[2]), 32'd0);
        run(200);
        chk("a_order_n", 32'(order_q.size()), 32'd2);
        chk("a_order0", 32'(order_q.size() > 0 ? order_q[0] : -1), 32'd0);
        chk("a_order1", 32'(order_q.size() > 1 ? order_q[1] : -1), 32'd2);
        chk("a_leak", 32'(leak), 32'd0);
        chk("a_ptr", 32'(dut.rr_ptr), 32'd3);

        // Single requester 1, 8-byte frame ending with tuser=1
        order_q.delete();
        tot_beats = 0;
        start_req(1, 1, 8, 16'h1234, 1'b1);
        chk("b_pre_grant", 32'(grant_valid), 32'd0);
        cyc();
        chk("b_grant_valid", 32'(grant_valid), 32'd1);
        chk("b_grant_idx", 32'(grant_idx), 32'd1);
        chk("b_dest_port", 32'(m_udp_dest_port), 32'h1234);
        chk("b_length", 32'(m_udp_length), 32'd16);
        chk("b_hdr_ready", 32'(s_hdr_ready), 32'b0010);
        run(200);
        chk("b_beats", 32'(tot_beats), 32'd8);
        chk("b_frame_count", frame_count, 32'd3);

        // Reset mid-payload of requester 3 while requester 1 waits
        order_q.delete();
        start_req(3, 1, 8, 16'h3333, 1'b0);
        start_req(1, 1, 4, 16'h1111, 1'b0);
        repeat (5) cyc();
        chk("r_pre_idx", 32'(grant_idx), 32'd3);
        chk("r_pre_tvalid", 32'(m_tvalid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("r_tvalid", 32'(m_tvalid), 32'd0);
        chk("r_readies", 32'({s_tready, s_hdr_ready}), 32'd0);
        chk("r_hdr_valid", 32'(m_udp_hdr_valid), 32'd0);
        chk("r_grant_valid", 32'(grant_valid), 32'd0);
        chk("r_frame_count", frame_count, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_src();
        fc_exp = 32'd0;
        start_req(3, 1, 8, 16'h3333, 1'b0);
        start_req(1, 1, 4, 16'h1111, 1'b0);
        #1;
        cyc();
        chk("r_next_grant", 32'(grant_idx), 32'd1);
        run(200);
        chk("r_order0", 32'(order_q.size() > 0 ? order_q[0] : -1), 32'd1);
        chk("r_order1", 32'(order_q.size() > 1 ? order_q[1] : -1), 32'd3);

        // All four requesting continuously, two frames each
        do_reset();
        for (int r = 0; r < N; r++) start_req(r, 2, 4, 16'h2000 + 16'(r), 1'b0);
        run(400);
        chk("c_order_n", 32'(order_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk("c_order", 32'(order_q.size() > i ? order_q[i] : -1), 32'(i % 4));
        chk("c_frame_count", frame_count, 32'd8);
        chk("c_leak", 32'(leak), 32'd0);

        // Random sink backpressure during requester 3 with requester 0 waiting
        order_q.delete();
        rand_rdy = 1'b1;
        start_req(3, 1, 8, 16'h3333, 1'b0);
        cyc();
        start_req(0, 1, 3, 16'h0000, 1'b0);
        run(400);
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        chk("d_order_n", 32'(order_q.size()), 32'd2);
        chk("d_order0", 32'(order_q.size() > 0 ? order_q[0] : -1), 32'd3);
        chk("d_order1", 32'(order_q.size() > 1 ? order_q[1] : -1), 32'd0);
        chk("d_leak", 32'(leak), 32'd0);

        // frame_count wrap
        force dut.frame_count = 32'hFFFF_FFFF;
        #1;
        release dut.frame_count;
        fc_exp = 32'hFFFF_FFFF;
        start_req(2, 1, 2, 16'h0202, 1'b0);
        run(100);
        chk("e_wrap", frame_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
